// File: rtl/bp_weight_updater_pkg.sv
// bp_pkg: shared constants and FSM encoding for the backprop weight-update path
package bp_pkg;
  localparam logic [31:0] FP_ONE         = 32'h3F80_0000;
  localparam logic [31:0] LEARN_RATE     = 32'h3E4C_CCCD;
  localparam int          BP_PIPE_LAT    = 7;
  localparam int          BP_OLD_W_DELAY = 6;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} bp_state_e;
endpackage

// File: rtl/bp_weight_updater_if.sv
// bp_weight_updater_if: control, datapath and host-access signals of the weight updater
interface bp_weight_updater_if #(parameter int IDX_W = 4) ();
  logic             start, busy, done, issue_valid, ld_en;
  logic [IDX_W-1:0] issue_idx, ld_addr, rd_addr;
  logic [31:0]      w_old, w_new, ld_data, rd_data;
  modport slave (
    input  start, w_new, ld_en, ld_addr, ld_data, rd_addr,
    output busy, done, issue_valid, issue_idx, w_old, rd_data
  );
  modport master (
    output start, w_new, ld_en, ld_addr, ld_data, rd_addr,
    input  busy, done, issue_valid, issue_idx, w_old, rd_data
  );
endinterface

// File: rtl/bp_valid_delay.sv
// bp_valid_delay: resettable DEPTH-stage shift register of W-bit words
module bp_valid_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pipe_q [DEPTH];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/bp_weight_updater.sv
// bp_weight_updater: pass sequencer and flop-based weight store for the backprop weight update
module bp_weight_updater
  import bp_pkg::*;
#(
  parameter int N_WEIGHTS   = 16,
  parameter int IDX_W       = 4,
  parameter int PIPE_LAT    = BP_PIPE_LAT,
  parameter int OLD_W_DELAY = BP_OLD_W_DELAY
) (
  input logic                clk,
  input logic                reset,
  bp_weight_updater_if.slave bus
);
  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, dly_idx;
  logic [31:0]      weights_q [N_WEIGHTS];
  logic [31:0]      fetch_q;
  logic             idle, issuing, last_idx, dly_valid, last_wr;
  assign idle     = state_q == IDLE;
  assign issuing  = state_q == ISSUE;
  assign last_idx = idx_q == IDX_W'(N_WEIGHTS - 1);
  // the pass ends once the final index's write lands, which empties the pipe
  assign last_wr  = dly_valid && dly_idx == IDX_W'(N_WEIGHTS - 1);
  always_comb begin
    state_d = idle && bus.start ? ISSUE
            : issuing && last_idx ? DRAIN
            : state_q == DRAIN && last_wr ? DONE
            : state_q == DONE ? IDLE : state_q;
    idx_d   = idle && bus.start ? '0 : issuing && !last_idx ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fetch_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (issuing) fetch_q <= weights_q[idx_q];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_WEIGHTS; i++) weights_q[i] <= '0;
    end else if (dly_valid) begin
      weights_q[dly_idx] <= bus.w_new;
    end else if (bus.ld_en && idle) begin
      weights_q[bus.ld_addr] <= bus.ld_data;
    end
  end
  bp_valid_delay #(.W(IDX_W + 1), .DEPTH(PIPE_LAT)) u_issue_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   ({issuing, idx_q}),
    .q_o   ({dly_valid, dly_idx})
  );
  // fetch register supplies one cycle of the old-weight alignment
  bp_valid_delay #(.W(32), .DEPTH(OLD_W_DELAY - 1)) u_wold_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (fetch_q),
    .q_o   (bus.w_old)
  );
  assign bus.busy        = issuing || state_q == DRAIN;
  assign bus.done        = state_q == DONE;
  assign bus.issue_valid = issuing;
  assign bus.issue_idx   = idx_q;
  assign bus.rd_data     = weights_q[bus.rd_addr];
endmodule
